// File: rtl/gate_vec_seq.sv
// Drives the four (a,b) operand vectors into an external gate block and checks its eight results.
// Compare logic is only built when GATE_VEC_SEQ_CHECK_EN is defined.
module gate_vec_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int LOOPS       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       ya,
  input  logic       yna,
  input  logic       yo,
  input  logic       yno,
  input  logic       yx,
  input  logic       yxn,
  input  logic       ynota,
  input  logic       ynotb,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic [7:0] err_cnt,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] loop_cnt_q, loop_cnt_d;
  logic [1:0] vec_idx_q, vec_idx_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       mismatch_q, mismatch_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [1:0] vec_inc;
  logic       vec_bad;

  assign vec_inc = vec_idx_q + 2'd1;

`ifdef GATE_VEC_SEQ_CHECK_EN
  logic [7:0] results;
  logic [7:0] expected;

  assign results  = {ya, yna, yo, yno, yx, yxn, ynota, ynotb};
  // Reference is taken from the registered operands, which are stable throughout SAMPLE.
  assign expected = {a_q & b_q, ~(a_q & b_q), a_q | b_q, ~(a_q | b_q),
                     a_q ^ b_q, ~(a_q ^ b_q), ~a_q, ~b_q};
  assign vec_bad  = (results != expected);
`else
  logic unused_results;

  assign unused_results = ^{ya, yna, yo, yno, yx, yxn, ynota, ynotb};
  assign vec_bad        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    loop_cnt_d = loop_cnt_q;
    vec_idx_d  = vec_idx_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mismatch_d = 1'b0;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_DRIVE;
          hold_cnt_d = 8'd0;
          loop_cnt_d = 8'd0;
          vec_idx_d  = 2'd0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          busy_d     = 1'b1;
          err_cnt_d  = 8'd0;
        end
      end

      S_DRIVE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_SAMPLE;
          hold_cnt_d = 8'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      S_SAMPLE: begin
        if (vec_bad) begin
          mismatch_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        if (vec_idx_q == 2'd3 && loop_cnt_q == LOOP_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d   = S_DRIVE;
          vec_idx_d = vec_inc;
          a_d       = vec_inc[0];
          b_d       = vec_inc[1];
          if (vec_idx_q == 2'd3) begin
            loop_cnt_d = loop_cnt_q + 8'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= 8'd0;
      loop_cnt_q <= 8'd0;
      vec_idx_q  <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      loop_cnt_q <= loop_cnt_d;
      vec_idx_q  <= vec_idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
  assign vec_idx  = vec_idx_q;

endmodule

// File: tb/tb_gate_vec_seq.sv
// Bench for gate_vec_seq: three instances with a behavioural gate block (healthy, XOR stuck low,
// fully inverted) checked each cycle against a cycle-position model of the run.
module tb_gate_vec_seq;

`ifdef GATE_VEC_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int NI = 3;
  localparam int HS [NI] = '{4, 4, 1};
  localparam int LS [NI] = '{1, 2, 255};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] a, b, busy, done, mismatch;
  logic [7:0] err_cnt [NI];
  logic [1:0] vec_idx [NI];
  int fault_mode [NI] = '{0, 1, 2};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gate_ideal(input logic ai, input logic bi);
    return {ai & bi, ~(ai & bi), ai | bi, ~(ai | bi), ai ^ bi, ~(ai ^ bi), ~ai, ~bi};
  endfunction

  function automatic logic [7:0] gate_out(input int fm, input logic ai, input logic bi);
    logic [7:0] g;
    g = gate_ideal(ai, bi);
    if (fm == 1) g[3] = 1'b0;
    else if (fm == 2) g = ~g;
    return g;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [7:0] y;
    always_comb y = gate_out(fault_mode[gi], a[gi], b[gi]);

    gate_vec_seq #(.HOLD_CYCLES(HS[gi]), .LOOPS(LS[gi])) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[gi]),
      .a(a[gi]), .b(b[gi]),
      .ya(y[7]), .yna(y[6]), .yo(y[5]), .yno(y[4]),
      .yx(y[3]), .yxn(y[2]), .ynota(y[1]), .ynotb(y[0]),
      .busy(busy[gi]), .done(done[gi]), .mismatch(mismatch[gi]),
      .err_cnt(err_cnt[gi]), .vec_idx(vec_idx[gi])
    );
  end

  // ---------------- behavioural model ----------------
  bit         m_act [NI];
  int         m_k [NI];
  logic       m_a [NI], m_b [NI], m_busy [NI], m_done [NI], m_mis [NI];
  logic [1:0] m_vec [NI];
  logic [7:0] m_err [NI];

  function automatic bit vec_is_bad(input int i, input int v);
    logic [1:0] vv;
    vv = v[1:0];
    if (!CHK) return 1'b0;
    return gate_out(fault_mode[i], vv[0], vv[1]) != gate_ideal(vv[0], vv[1]);
  endfunction

  function automatic int err_after(input int i, input int nv);
    int pop, tot;
    pop = 0;
    for (int v = 0; v < 4; v++) if (vec_is_bad(i, v)) pop++;
    tot = (nv / 4) * pop;
    for (int v = 0; v < nv % 4; v++) if (vec_is_bad(i, v)) tot++;
    return (tot > 255) ? 255 : tot;
  endfunction

  task automatic model_reset(input int i);
    m_act[i] = 0; m_k[i] = 0; m_a[i] = 0; m_b[i] = 0; m_vec[i] = 0;
    m_busy[i] = 0; m_done[i] = 0; m_mis[i] = 0; m_err[i] = 0;
  endtask

  // Outputs after the k-th edge of a run (k=0 is the start-accept edge).
  task automatic model_eval(input int i);
    int p, n, k, nv;
    logic [1:0] v;
    p = HS[i] + 1;
    n = 4 * LS[i] * p;
    k = m_k[i];
    nv = k / p;
    if (k < n) begin
      v = 2'(nv % 4);
      m_busy[i] = 1; m_done[i] = 0; m_vec[i] = v; m_a[i] = v[0]; m_b[i] = v[1];
    end else begin
      m_busy[i] = 0; m_done[i] = 1;
    end
    m_mis[i] = (k > 0 && k % p == 0) ? vec_is_bad(i, (nv - 1) % 4) : 1'b0;
    m_err[i] = 8'(err_after(i, nv));
  endtask

  initial for (int i = 0; i < NI; i++) model_reset(i);

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        model_reset(i);
      end else if (m_act[i]) begin
        m_k[i]++;
        if (m_k[i] > 4 * LS[i] * (HS[i] + 1)) begin
          m_act[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_mis[i] = 0;
        end else begin
          model_eval(i);
        end
      end else begin
        m_done[i] = 0;
        m_mis[i] = 0;
        if (start[i]) begin
          m_act[i] = 1;
          m_k[i] = 0;
          model_eval(i);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  int done_cyc [NI] = '{0, 0, 0};
  int done_cnt [NI] = '{0, 0, 0};
  int mis_cnt [NI] = '{0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d_a", i), 32'(a[i]), 32'(m_a[i]));
      check($sformatf("i%0d_b", i), 32'(b[i]), 32'(m_b[i]));
      check($sformatf("i%0d_vec_idx", i), 32'(vec_idx[i]), 32'(m_vec[i]));
      check($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(m_busy[i]));
      check($sformatf("i%0d_done", i), 32'(done[i]), 32'(m_done[i]));
      check($sformatf("i%0d_mismatch", i), 32'(mismatch[i]), 32'(m_mis[i]));
      check($sformatf("i%0d_err_cnt", i), 32'(err_cnt[i]), 32'(m_err[i]));
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        if (done_cyc[i] == 0) done_cyc[i] = cyc;
      end
      if (mismatch[i] === 1'b1) mis_cnt[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int base, snap_done, snap_mis;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_a", 32'(a[0]), 0);
    check("rst_b", 32'(b[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_mismatch", 32'(mismatch[0]), 0);
    check("rst_err_cnt", 32'(err_cnt[0]), 0);
    check("rst_vec_idx", 32'(vec_idx[0]), 0);

    // Release reset and request all three runs together; accept is the very next edge.
    tick(3);
    rst_n = 1'b1;
    start = '1;
    base = cyc;
    tick(1);
    start = '0;
    tick(2100);
    check("done_cycle_h4_l1", 32'(done_cyc[0] - base), 21);
    check("done_cycle_h4_l2", 32'(done_cyc[1] - base), 41);
    check("done_cycle_h1_l255", 32'(done_cyc[2] - base), 2041);
    check("mis_pulses_clean", 32'(mis_cnt[0]), 0);
    check("err_cnt_clean", 32'(err_cnt[0]), 0);
    check("mis_pulses_xor0", 32'(mis_cnt[1]), CHK ? 4 : 0);
    check("err_cnt_xor0", 32'(err_cnt[1]), CHK ? 4 : 0);
    check("mis_pulses_inv", 32'(mis_cnt[2]), CHK ? 1020 : 0);
    check("err_cnt_inv_sat", 32'(err_cnt[2]), CHK ? 255 : 0);
    check("vec_idx_hold", 32'(vec_idx[1]), 3);

    // start held high: back-to-back runs, each starting on the cycle after DONE.
    fault_mode[0] = 1;
    snap_done = done_cnt[0];
    start[0] = 1'b1;
    tick(50);
    check("held_start_done_pulses", 32'(done_cnt[0] - snap_done), 2);
    start[0] = 1'b0;
    tick(30);
    check("held_start_err_cnt", 32'(err_cnt[0]), CHK ? 2 : 0);

    // Reset asserted between edges on cycle 7 of a run.
    fault_mode[0] = 0;
    snap_done = done_cnt[0];
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("pre_rst_a", 32'(a[0]), 1);
    check("pre_rst_vec_idx", 32'(vec_idx[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_a", 32'(a[0]), 0);
    check("async_rst_busy", 32'(busy[0]), 0);
    check("async_rst_vec_idx", 32'(vec_idx[0]), 0);
    check("async_rst_err_cnt", 32'(err_cnt[1]), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("no_done_after_abort", 32'(done_cnt[0] - snap_done), 0);
    snap_mis = mis_cnt[0];
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    check("restart_vec_idx", 32'(vec_idx[0]), 0);
    tick(25);
    check("restart_done_pulses", 32'(done_cnt[0] - snap_done), 1);
    check("restart_mis_pulses", 32'(mis_cnt[0] - snap_mis), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
